ha_array_accum_ctrl: RTL and testbench

//  Sequential final-adder controller for the 8x8 approximate multiplier's half-adder row array.

---
 rtl/ha_acc_pkg.sv | 39 +++
 rtl/ha_row_align.sv | 24 ++
 rtl/ha_array_accum_ctrl.sv | 128 ++++++++++++
 tb/tb_ha_array_accum_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ha_acc_pkg.sv
// Shared types, sizes and row-alignment helpers for the half-adder array accumulator.
// Optional zero-row skipping is enabled with HA_ACC_SKIP_ZERO_EN (see ha_array_accum_ctrl).
package ha_acc_pkg;

  localparam int ROWS      = 4;
  localparam int T_W       = 9;
  localparam int B_W       = 7;
  localparam int P_W       = 16;
  localparam int ROW_SHIFT = 2;
  localparam int A_W       = P_W + 2;
  localparam int RW        = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Row k sits at weight 2^(2k); its carry vector sits one row-step higher.
  function automatic logic [A_W-1:0] row_align(input logic [RW-1:0] k,
                                               input logic [T_W-1:0] t,
                                               input logic [B_W-1:0] b);
    logic [A_W-1:0] t_ext;
    logic [A_W-1:0] b_ext;
    t_ext = A_W'(t) << (ROW_SHIFT * int'(k));
    b_ext = A_W'(b) << (ROW_SHIFT * int'(k) + ROW_SHIFT);
    return t_ext + b_ext;
  endfunction

  function automatic logic [RW-1:0] first_row(input logic [ROWS-1:0] mask);
    logic [RW-1:0] r;
    r = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (mask[i]) r = RW'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ha_row_align.sv
// Selects one captured row pair and presents it as an 18-bit addend aligned to its weight.
module ha_row_align
  import ha_acc_pkg::*;
(
  input  logic [RW-1:0]       row_sel,
  input  logic [ROWS*T_W-1:0] t_all,
  input  logic [ROWS*B_W-1:0] b_all,
  output logic [A_W-1:0]      addend
);

  logic [T_W-1:0] t_row [ROWS];
  logic [B_W-1:0] b_row [ROWS];

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_split
      assign t_row[gi] = t_all[gi*T_W +: T_W];
      assign b_row[gi] = b_all[gi*B_W +: B_W];
    end
  endgenerate

  assign addend = row_align(row_sel, t_row[row_sel], b_row[row_sel]);

endmodule

// File: rtl/ha_array_accum_ctrl.sv
// Sequential final adder: captures four row pairs, sums one row per cycle into a 16-bit product.
// Define HA_ACC_SKIP_ZERO_EN to skip rows whose sum and carry vectors are both zero.
module ha_array_accum_ctrl
  import ha_acc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [T_W-1:0] ha_array_0_t,
  input  logic [T_W-1:0] ha_array_1_t,
  input  logic [T_W-1:0] ha_array_2_t,
  input  logic [T_W-1:0] ha_array_3_t,
  input  logic [B_W-1:0] ha_array_0_b,
  input  logic [B_W-1:0] ha_array_1_b,
  input  logic [B_W-1:0] ha_array_2_b,
  input  logic [B_W-1:0] ha_array_3_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] p,
  output logic           p_ovf
);

  state_e              state_q;
  logic [RW-1:0]       row_q;
  logic [ROWS-1:0]     pend_q;
  logic [P_W-1:0]      acc_q;
  logic                ovf_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [ROWS*T_W-1:0] t_q;
  logic [ROWS*B_W-1:0] b_q;

  logic [ROWS*T_W-1:0] t_in;
  logic [ROWS*B_W-1:0] b_in;
  logic [ROWS-1:0]     seq_mask;
  logic [ROWS-1:0]     pend_rem;
  logic [A_W-1:0]      addend;
  logic [A_W-1:0]      sum;

  assign t_in = {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
  assign b_in = {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};

  // seq_mask marks the rows that will be sequenced for the operation being accepted.
`ifdef HA_ACC_SKIP_ZERO_EN
  logic [ROWS-1:0] nz_in;
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_nz
      assign nz_in[gi] = (|t_in[gi*T_W +: T_W]) | (|b_in[gi*B_W +: B_W]);
    end
  endgenerate
  assign seq_mask = nz_in;
`else
  assign seq_mask = '1;
`endif

  assign pend_rem = pend_q & ~(ROWS'(1) << row_q);

  ha_row_align u_align (
    .row_sel (row_q),
    .t_all   (t_q),
    .b_all   (b_q),
    .addend  (addend)
  );

  assign sum = A_W'(acc_q) + addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      pend_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            t_q        <= t_in;
            b_q        <= b_in;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            pend_q     <= seq_mask;
            row_q      <= first_row(seq_mask);
            in_ready_q <= 1'b0;
            if (|seq_mask) begin
              state_q <= ACCUM;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          acc_q <= sum[P_W-1:0];
          if (|sum[A_W-1:P_W]) ovf_q <= 1'b1;
          pend_q <= pend_rem;
          row_q  <= first_row(pend_rem);
          if (pend_rem == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = acc_q;
  assign p_ovf     = ovf_q;

endmodule

// File: tb/tb_ha_array_accum_ctrl.sv
// Self-checking bench for ha_array_accum_ctrl: directed cases plus randomized back-to-back traffic.
// Honours HA_ACC_SKIP_ZERO_EN for the expected latency.
module tb_ha_array_accum_ctrl;

`ifdef HA_ACC_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [35:0] tv = '0;
  logic [27:0] bv = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] p;
  logic        p_ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ha_array_accum_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_t (tv[8:0]),
    .ha_array_1_t (tv[17:9]),
    .ha_array_2_t (tv[26:18]),
    .ha_array_3_t (tv[35:27]),
    .ha_array_0_b (bv[6:0]),
    .ha_array_1_b (bv[13:7]),
    .ha_array_2_b (bv[20:14]),
    .ha_array_3_b (bv[27:21]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .p            (p),
    .p_ovf        (p_ovf)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Exact product of the four row pairs, each at its arithmetic weight.
  function automatic int ref_sum(input logic [35:0] t, input logic [27:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++)
      s += int'(t[9*k +: 9]) * (4 ** k) + int'(b[7*k +: 7]) * (4 ** k) * 4;
    return s;
  endfunction

  function automatic int ref_lat(input logic [35:0] t, input logic [27:0] b);
    int n;
    n = 1;
    for (int k = 0; k < 4; k++)
      if (t[9*k +: 9] != 0 || b[7*k +: 7] != 0) n++;
    return SKIP ? n : 5;
  endfunction

  task automatic rand_vec(output logic [35:0] t, output logic [27:0] b);
    t = '0;
    b = '0;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(3) != 0) begin
        t[9*k +: 9] = 9'($urandom);
        b[7*k +: 7] = 7'($urandom);
      end
      if ($urandom_range(7) == 0) begin
        t[9*k +: 9] = 9'h1FF;
        b[7*k +: 7] = 7'h7F;
      end
    end
  endtask

  // Reference: queue of accepted operations with the edge at which each product becomes visible.
  int q_sum[$];
  int q_vis[$];
  bit m_busy;
  bit m_ov;

  always @(negedge clk) begin
    if (rst) begin
      q_sum.delete();
      q_vis.delete();
    end else begin
      m_busy = (q_sum.size() > 0);
      m_ov   = m_busy && (cyc >= q_vis[0]);
      chk("mon_in_ready", in_ready, !m_busy);
      chk("mon_out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("mon_p", p, q_sum[0] % 65536);
        chk("mon_p_ovf", p_ovf, (q_sum[0] >= 65536) ? 1 : 0);
        if (out_ready) begin
          void'(q_sum.pop_front());
          void'(q_vis.pop_front());
        end
      end
      if (in_valid && !m_busy) begin
        q_sum.push_back(ref_sum(tv, bv));
        q_vis.push_back(cyc + ref_lat(tv, bv));
      end
    end
  end

  task automatic do_txn(input logic [35:0] t_in, input logic [27:0] b_in, input int hold,
                        output int got_p, output int got_ovf, output int lat);
    int n;
    int a_cyc;
    got_p = -1;
    got_ovf = -1;
    lat = -1;
    @(posedge clk); #1;
    tv = t_in;
    bv = b_in;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    a_cyc = cyc;
    in_valid = 1'b0;
    tv = {4'($urandom), 32'($urandom)};
    bv = 28'($urandom);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("result_timeout", 0, 1);
      return;
    end
    lat = cyc - a_cyc + 1;
    got_p = int'(p);
    got_ovf = int'(p_ovf);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid = (h == 1);
      @(negedge clk);
      chk("hold_p", p, got_p);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gp;
    int go;
    int lat;
    int k;
    int n;
    int e;
    int prev_acc;
    int prev_lat;
    logic [35:0] rt;
    logic [27:0] rb;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    chk("rst_p_ovf", p_ovf, 0);

    chk("model_all_max", ref_sum({4{9'h1FF}}, {4{7'h7F}}), 86615);
    chk("model_b3", ref_sum(36'h0, {7'h7F, 21'h0}), 32512);

    do_txn(36'h0, 28'h0, 0, gp, go, lat);
    chk("zero_p", gp, 16'h0000);
    chk("zero_ovf", go, 0);
    chk("zero_latency", lat, SKIP ? 1 : 5);

    do_txn(36'h1, 28'h0, 0, gp, go, lat);
    chk("t0_lsb_p", gp, 16'h0001);
    chk("t0_lsb_ovf", go, 0);
    chk("t0_lsb_latency", lat, SKIP ? 2 : 5);

    do_txn(36'h0, {7'h7F, 21'h0}, 0, gp, go, lat);
    chk("b3_p", gp, 16'h7F00);
    chk("b3_ovf", go, 0);

    do_txn({4{9'h1FF}}, {4{7'h7F}}, 3, gp, go, lat);
    chk("max_p", gp, 16'h5257);
    chk("max_ovf", go, 1);
    chk("max_latency", lat, 5);

    // Reset lands on the third accumulate edge of an all-rows-nonzero operation.
    @(posedge clk); #1;
    tv = {4'($urandom), 32'($urandom)} | 36'h008040201;
    bv = 28'($urandom);
    in_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_p", p, 0);
    chk("midrst_p_ovf", p_ovf, 0);

    rand_vec(rt, rb);
    rt[0] = 1'b1;
    do_txn(rt, rb, 1, gp, go, lat);
    chk("post_rst_p", gp, ref_sum(rt, rb) % 65536);
    chk("post_rst_ovf", go, (ref_sum(rt, rb) >= 65536) ? 1 : 0);

    // Back-to-back traffic; the per-product values are checked by the monitor.
    @(posedge clk); #1;
    rand_vec(rt, rb);
    tv = rt;
    bv = rb;
    in_valid = 1'b1;
    out_ready = 1'b1;
    prev_acc = -1;
    prev_lat = 0;
    k = 0;
    n = 0;
    while (k < 200 && n < 5000) begin
      @(negedge clk);
      n++;
      if (in_ready) begin
        e = cyc + 1;
        if (prev_acc >= 0) chk("b2b_spacing", e - prev_acc, prev_lat + 1);
        prev_acc = e;
        prev_lat = ref_lat(tv, bv);
        @(posedge clk); #1;
        rand_vec(rt, rb);
        tv = rt;
        bv = rb;
        k++;
      end
    end
    chk("b2b_count", k, 200);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("drain_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
